// File: rtl/module_bcd_display.sv
// Signed binary to sign + BCD converter for the 7-segment path.
// Uses iterative double dabble (one bit per clock) behind a start/busy/valid handshake.
module module_bcd_display #(
  parameter int IN_W   = 16,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [IN_W-1:0]       dato_i,
  output logic                  busy,
  output logic                  valid,
  output logic                  signo_o,
  output logic [4*DIGITS-1:0]   bcd_o,
  output logic                  ovf
);

  localparam int          ACC_W = 4 * (DIGITS + 1);
  localparam int          CNT_W = (IN_W > 1) ? $clog2(IN_W) : 1;
  localparam logic [63:0] LIMIT = 64'(10**DIGITS - 1);

  typedef enum logic [1:0] {IDLE, ABS, SHIFT, DONE} state_t;

  state_t              state_q, state_d;
  logic [IN_W-1:0]     din_q, din_d;
  logic [IN_W-1:0]     mag_q, mag_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                sign_q, sign_d;
  logic                ovfl_q, ovfl_d;
  logic                signo_q, signo_d;
  logic                ovf_q, ovf_d;
  logic [4*DIGITS-1:0] bcd_q, bcd_d;

  logic [IN_W:0]       ext, mag_full;
  logic [ACC_W-1:0]    adj, acc_sh;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      din_q   <= '0;
      mag_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      sign_q  <= 1'b0;
      ovfl_q  <= 1'b0;
      signo_q <= 1'b0;
      ovf_q   <= 1'b0;
      bcd_q   <= '0;
    end else begin
      state_q <= state_d;
      din_q   <= din_d;
      mag_q   <= mag_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sign_q  <= sign_d;
      ovfl_q  <= ovfl_d;
      signo_q <= signo_d;
      ovf_q   <= ovf_d;
      bcd_q   <= bcd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    din_d   = din_q;
    mag_d   = mag_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    sign_d  = sign_q;
    ovfl_d  = ovfl_q;
    signo_d = signo_q;
    ovf_d   = ovf_q;
    bcd_d   = bcd_q;

    // One extra bit so the most negative input has an exact magnitude.
    ext      = {din_q[IN_W-1], din_q};
    mag_full = din_q[IN_W-1] ? -ext : ext;

    for (int i = 0; i < DIGITS + 1; i++)
      adj[4*i +: 4] = (acc_q[4*i +: 4] >= 4'd5) ? acc_q[4*i +: 4] + 4'd3 : acc_q[4*i +: 4];
    acc_sh = ACC_W'({adj, mag_q[IN_W-1]});

    case (state_q)
      IDLE: begin
        if (start) begin
          din_d   = dato_i;
          state_d = ABS;
        end
      end
      ABS: begin
        sign_d  = din_q[IN_W-1];
        ovfl_d  = {{(63-IN_W){1'b0}}, mag_full} > LIMIT;
        mag_d   = mag_full[IN_W-1:0];
        acc_d   = '0;
        cnt_d   = '0;
        state_d = SHIFT;
      end
      SHIFT: begin
        acc_d = acc_sh;
        mag_d = {mag_q[IN_W-2:0], 1'b0};
        cnt_d = cnt_q + CNT_W'(1);
        // Outputs load on the final shift so they are already stable while valid is high.
        if (cnt_q == CNT_W'(IN_W - 1)) begin
          bcd_d   = ovfl_q ? {DIGITS{4'h9}} : acc_sh[4*DIGITS-1:0];
          signo_d = sign_q;
          ovf_d   = ovfl_q;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy    = (state_q != IDLE);
  assign valid   = (state_q == DONE);
  assign signo_o = signo_q;
  assign ovf     = ovf_q;
  assign bcd_o   = bcd_q;

endmodule

// File: tb/tb_module_bcd_display.sv
// Directed bench for module_bcd_display: a scoreboard queue of expected results
// is popped by a monitor on each valid pulse; stimulus checks timing/handshake.
module tb_module_bcd_display;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] dato_i;
  logic        busy, valid, signo_o, ovf;
  logic [15:0] bcd_o;

  int errors = 0;
  int checks = 0;

  typedef struct packed {logic s; logic o; logic [15:0] b;} exp_t;
  exp_t q[$];
  exp_t e;

  module_bcd_display #(.IN_W(16), .DIGITS(4)) dut (
    .clk(clk), .rst(rst), .start(start), .dato_i(dato_i),
    .busy(busy), .valid(valid), .signo_o(signo_o), .bcd_o(bcd_o), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Monitor: every valid pulse must match the oldest expected result.
  always @(negedge clk) begin
    if (valid === 1'b1) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid: got bcd=%h sign=%b ovf=%b with no pending conversion",
                 bcd_o, signo_o, ovf);
      end else begin
        e = q.pop_front();
        if ({signo_o, ovf, bcd_o} !== e) begin
          errors++;
          $display("FAIL result: got sign=%b ovf=%b bcd=%h expected sign=%b ovf=%b bcd=%h",
                   signo_o, ovf, bcd_o, e.s, e.o, e.b);
        end
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("idle_timeout", 32'(busy), 32'h0);
  endtask

  task automatic conv(input logic [15:0] d, input logic [15:0] eb, input logic es, input logic eo);
    int lat, nbusy;
    lat   = -1;
    nbusy = 0;
    wait_idle();
    start  = 1'b1;
    dato_i = d;
    q.push_back({es, eo, eb});
    @(posedge clk);
    #1;
    start  = 1'b0;
    dato_i = 16'h5A5A;
    for (int k = 1; k <= 30 && lat < 0; k++) begin
      @(negedge clk);
      if (busy) nbusy++;
      if (valid) lat = k;
    end
    chk("latency", 32'(lat), 32'd18);
    chk("busy_cycles", 32'(nbusy), 32'd18);
    @(negedge clk);
    chk("idle_after_done", 32'(busy), 32'h0);
    repeat (3) @(negedge clk);
    chk("bcd_hold", 32'(bcd_o), 32'(eb));
  endtask

  initial begin
    int lat1, lat2, nv;
    rst    = 1'b0;
    start  = 1'b0;
    dato_i = '0;
    @(negedge clk);
    chk("rst_busy",  32'(busy),    32'h0);
    chk("rst_valid", 32'(valid),   32'h0);
    chk("rst_sign",  32'(signo_o), 32'h0);
    chk("rst_ovf",   32'(ovf),     32'h0);
    chk("rst_bcd",   32'(bcd_o),   32'h0);
    rst = 1'b1;
    @(negedge clk);

    conv(16'd9801, 16'h9801, 1'b0, 1'b0);
    conv(16'hFFD6, 16'h0042, 1'b1, 1'b0);
    conv(16'h0000, 16'h0000, 1'b0, 1'b0);
    conv(16'h8000, 16'h9999, 1'b1, 1'b1);
    conv(16'd10000, 16'h9999, 1'b0, 1'b1);
    conv(16'd9999, 16'h9999, 1'b0, 1'b0);
    conv(16'hFFFF, 16'h0001, 1'b1, 1'b0);

    // Back-to-back: start held through busy; second input sampled on first IDLE cycle.
    wait_idle();
    start  = 1'b1;
    dato_i = 16'd5;
    q.push_back({1'b0, 1'b0, 16'h0005});
    q.push_back({1'b0, 1'b0, 16'h0007});
    @(posedge clk);
    #1;
    dato_i = 16'd7;
    lat1 = -1; lat2 = -1; nv = 0;
    for (int k = 1; k <= 60 && lat2 < 0; k++) begin
      @(negedge clk);
      if (valid) begin
        nv++;
        if (lat1 < 0) lat1 = k; else lat2 = k;
      end
    end
    start = 1'b0;
    chk("b2b_lat1", 32'(lat1), 32'd18);
    chk("b2b_lat2", 32'(lat2), 32'd37);
    @(negedge clk);
    chk("b2b_idle", 32'(busy), 32'h0);

    // Reset mid-conversion of -1234: no valid, outputs cleared.
    wait_idle();
    start  = 1'b1;
    dato_i = 16'hFB2E;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (8) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_busy",  32'(busy),    32'h0);
    chk("abort_valid", 32'(valid),   32'h0);
    chk("abort_bcd",   32'(bcd_o),   32'h0);
    chk("abort_sign",  32'(signo_o), 32'h0);
    chk("abort_ovf",   32'(ovf),     32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (25) @(negedge clk);
    conv(16'hFB2E, 16'h1234, 1'b1, 1'b0);

    chk("scoreboard_empty", 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
